// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit feeding the HI/LO register file.
// MULT/MULTU take one compute cycle, DIV/DIVU run a restoring
// shift-subtract divider for DATA_WIDTH cycles, and MTHI/MTLO and
// divide-by-zero finish straight from IDLE. Every result is written
// through a one-cycle DONE state.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for start; the only state that accepts an op
// MUL    | product of the latched operands is formed this cycle
// DIV    | one quotient bit per cycle, counter 0..DATA_WIDTH-1
// DONE   | write strobe and done pulse, result on hilo_hi/hilo_lo

module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  hilo_write_en,
    output logic [DATA_WIDTH-1:0] hilo_hi,
    output logic [DATA_WIDTH-1:0] hilo_lo
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    // latched operands and operation attributes
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_signed;
    // divider working registers (magnitudes)
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [CNT_W-1:0] r_cnt;
    // result registers, held after the write
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic             w_accept;
    logic             w_op_mul;
    logic             w_op_div;
    logic             w_op_signed;
    logic             w_div_zero;
    logic             w_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic [2*W-1:0]   w_mul_a;
    logic [2*W-1:0]   w_mul_b;
    logic [2*W-1:0]   w_product;
    logic [W:0]       w_rem_sh;
    logic             w_ge;
    logic [W-1:0]     w_sub;
    logic [W-1:0]     w_rem_nx;
    logic [W-1:0]     w_quo_nx;
    logic [W-1:0]     w_q_fix;
    logic [W-1:0]     w_r_fix;

    assign w_accept    = (r_state == S_IDLE) && start && !flush && (op <= OP_MTLO);
    assign w_op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign w_op_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_div_zero  = (operand_b == '0);
    assign w_last      = (r_cnt == CNT_W'(DATA_WIDTH - 1));

    // Signed divide works on magnitudes; signs are reapplied at the end.
    assign w_a_neg = (op == OP_DIV) && operand_a[W-1];
    assign w_b_neg = (op == OP_DIV) && operand_b[W-1];
    assign w_a_mag = w_a_neg ? (~operand_a + W'(1)) : operand_a;
    assign w_b_mag = w_b_neg ? (~operand_b + W'(1)) : operand_b;

    // The low 2W bits of a sign-extended product equal the signed product.
    assign w_mul_a   = r_signed ? {{W{r_a[W-1]}}, r_a} : {{W{1'b0}}, r_a};
    assign w_mul_b   = r_signed ? {{W{r_b[W-1]}}, r_b} : {{W{1'b0}}, r_b};
    assign w_product = w_mul_a * w_mul_b;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // When it fits the true difference is below 2^W, so W-bit subtraction is exact.
    assign w_rem_sh = {r_rem, r_quo[W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_sub    = w_rem_sh[W-1:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[W-1:0];
    assign w_quo_nx = {r_quo[W-2:0], w_ge};
    assign w_q_fix  = r_neg_q ? (~w_quo_nx + W'(1)) : w_quo_nx;
    assign w_r_fix  = r_neg_r ? (~w_rem_nx + W'(1)) : w_rem_nx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode; flush aborts MUL/DIV but never a committed DONE
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op_mul) begin
                        w_state_nx = S_MUL;
                    end else if (w_op_div && !w_div_zero) begin
                        w_state_nx = S_DIV;
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_MUL: begin
                w_state_nx = flush ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                if (flush) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Operand capture, divider iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= operand_a;
                        r_b      <= operand_b;
                        r_signed <= w_op_signed;
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_cnt    <= '0;
                        if (op == OP_MTHI) begin
                            r_hi <= operand_a;
                            r_lo <= lo_i;
                        end else if (op == OP_MTLO) begin
                            r_hi <= hi_i;
                            r_lo <= operand_a;
                        end else if (w_op_div && w_div_zero) begin
                            // fixed divide-by-zero result: LO all ones, HI = dividend
                            r_hi <= operand_a;
                            r_lo <= '1;
                        end
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        r_hi <= w_product[2*W-1:W];
                        r_lo <= w_product[W-1:0];
                    end
                end
                S_DIV: begin
                    if (!flush) begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_hi <= w_r_fix;
                            r_lo <= w_q_fix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign hilo_write_en = (r_state == S_DONE);
    assign hilo_hi       = r_hi;
    assign hilo_lo       = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus random ops checked against
// an arithmetic reference model (longint multiply/divide).

module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] hi_i;
    logic [W-1:0] lo_i;
    logic         flush;
    logic         busy;
    logic         done;
    logic         hilo_write_en;
    logic [W-1:0] hilo_hi;
    logic [W-1:0] hilo_lo;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .hi_i          (hi_i),
        .lo_i          (lo_i),
        .flush         (flush),
        .busy          (busy),
        .done          (done),
        .hilo_write_en (hilo_write_en),
        .hilo_hi       (hilo_hi),
        .hilo_lo       (hilo_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result and number of edges after acceptance before write_en shows.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] h, input logic [W-1:0] l,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output int elat);
        longint      sp;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] up;
        eh = '0; el = '0; elat = 0;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                eh = up[63:32]; el = up[31:0]; elat = 1;
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32]; el = up[31:0]; elat = 1;
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    eh = a; el = '1; elat = 0;
                end else if (o == 3'd2) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0]; eh = r[31:0]; elat = 32;
                end else begin
                    el = a / b; eh = a % b; elat = 32;
                end
            end
            3'd4: begin eh = a; el = l; elat = 0; end
            default: begin eh = h; el = a; elat = 0; end
        endcase
    endtask

    // Issue one op, optionally hammer start while busy or flush during DONE.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] h, input logic [W-1:0] l,
                          input bit noise, input bit flush_done);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int elat;
        int lat;
        int nbusy;
        model(o, a, b, h, l, eh, el, elat);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b; hi_i = h; lo_i = l;
        @(posedge clk); #1;
        start = noise; op = 3'd4;
        operand_a = $urandom; operand_b = $urandom; hi_i = $urandom; lo_i = $urandom;
        lat = 0;
        nbusy = 0;
        while (!hilo_write_en && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (busy) nbusy++;
        check($sformatf("op%0d latency", o), 64'(lat), 64'(elat));
        check($sformatf("op%0d busy cycles", o), 64'(nbusy), 64'(elat + 1));
        check($sformatf("op%0d hi", o), 64'(hilo_hi), 64'(eh));
        check($sformatf("op%0d lo", o), 64'(hilo_lo), 64'(el));
        check($sformatf("op%0d done", o), 64'(done), 64'd1);
        if (flush_done) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check($sformatf("op%0d write_en after", o), 64'(hilo_write_en), 64'd0);
        check($sformatf("op%0d busy after", o), 64'(busy), 64'd0);
        check($sformatf("op%0d hi hold", o), 64'(hilo_hi), 64'(eh));
        check($sformatf("op%0d lo hold", o), 64'(hilo_lo), 64'(el));
    endtask

    initial begin
        int wrote;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int sel;

        rst = 1'b1; start = 1'b0; op = '0; flush = 1'b0;
        operand_a = '0; operand_b = '0; hi_i = '0; lo_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset write_en", 64'(hilo_write_en), 64'd0);
        check("reset hi", 64'(hilo_hi), 64'd0);
        check("reset lo", 64'(hilo_lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op(3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1, 1'b0);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op(3'd2, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0, 1'b1);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op(3'd3, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op(3'd4, 32'h600DF00D, 32'h0, 32'h11, 32'h22, 1'b0, 1'b0);

        // op 6/7 are no-ops
        for (int k = 6; k < 8; k++) begin
            @(negedge clk);
            start = 1'b1; op = 3'(k);
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("op%0d ignored busy", k), 64'(busy), 64'd0);
            check($sformatf("op%0d ignored write_en", k), 64'(hilo_write_en), 64'd0);
        end

        // flush and start together in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd4; operand_a = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", 64'(busy), 64'd0);
        check("flush+start write_en", 64'(hilo_write_en), 64'd0);

        // flush mid-divide at T+10, then MTLO accepted at T+11
        @(negedge clk);
        start = 1'b1; op = 3'd2; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wrote = 0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (hilo_write_en || done) wrote++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (hilo_write_en || done) wrote++;
        check("flush div busy", 64'(busy), 64'd0);
        check("flush div no write", 64'(wrote), 64'd0);
        run_op(3'd5, 32'h0000CAFE, 32'h0, 32'h55, 32'h77, 1'b0, 1'b0);

        // reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd3; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid write_en", 64'(hilo_write_en), 64'd0);
        check("rst mid done", 64'(done), 64'd0);
        check("rst mid hi", 64'(hilo_hi), 64'd0);
        check("rst mid lo", 64'(hilo_lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wrote = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (hilo_write_en) wrote++;
        end
        check("rst mid no write", 64'(wrote), 64'd0);

        // random ops against the model
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            run_op(3'($urandom_range(0, 5)), a, b, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS core's EX stage.
- It is the producer side of the HI/LO register file. It computes MULT/MULTU/DIV/DIVU results and performs MTHI/MTLO merges.
- It drives the register file's write channel: hilo_write_en, hilo_hi and hilo_lo.
- It asserts busy so the pipeline control stalls until the result is committed.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. The divider iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- start  input  1  op request; accepted only in IDLE
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6/7 are no-ops
- operand_a  input  DATA_WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
- operand_b  input  DATA_WIDTH  rt value (divisor / multiplier)
- hi_i  input  DATA_WIDTH  current HI, read from the register file
- lo_i  input  DATA_WIDTH  current LO, read from the register file
- flush  input  1  exception/branch flush; aborts the operation in flight
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse, coincident with hilo_write_en
- hilo_write_en  output  1  write strobe to the HI/LO register file
- hilo_hi  output  DATA_WIDTH  HI value to write
- hilo_lo  output  DATA_WIDTH  LO value to write

Behaviour:
- Priority: rst > flush > start.
- Reset: state=IDLE; busy=0, done=0, hilo_write_en=0, hilo_hi=0, hilo_lo=0; iteration counter=0.
- States: IDLE, MUL, DIV, DONE.

Acceptance:
- In IDLE with start=1, flush=0 and op in 0..5, the unit latches op, operands, hi_i and lo_i at edge T.
- start outside IDLE is ignored; there is no queueing.
- op 6/7 is ignored and the unit stays in IDLE.

MULT/MULTU:
- IDLE->MUL at T.
- MUL computes the 2*DATA_WIDTH product (signed or unsigned) into a register at T+1.
- DONE at T+2: hilo_hi = product[63:32], hilo_lo = product[31:0].

DIV/DIVU:
- Restoring shift-subtract divider on magnitudes.
  - Signed: take absolute values; the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
- IDLE->DIV at T. Counter runs 0..DATA_WIDTH-1, one quotient bit per cycle.
- DIV->DONE after the final iteration, so write_en is asserted in the cycle following edge T+32. Total latency: 33 edges from acceptance to write.
- Output mapping: hilo_lo = quotient, hilo_hi = remainder.
- Divisor=0: skip DIV and go IDLE->DONE at T. Result: hilo_lo = all ones, hilo_hi = operand_a (fixed, documented value).
- Signed 0x80000000 / 0xFFFFFFFF: hilo_lo = 0x80000000, hilo_hi = 0 (wrap, no trap).

MTHI / MTLO:
- IDLE->DONE at T.
- MTHI: hilo_hi = operand_a, hilo_lo = latched lo_i.
- MTLO: hilo_hi = latched hi_i, hilo_lo = operand_a.

DONE:
- hilo_write_en=1 and done=1 for exactly one cycle; then DONE->IDLE.
- hilo_hi and hilo_lo hold their last values after the write.

busy:
- Registered: high from the cycle after acceptance through the DONE cycle inclusive.
- A new start is accepted in the first IDLE cycle after DONE.

flush:
- In MUL or DIV: return to IDLE at that edge; no write, no done pulse.
- In DONE: the write still completes, because the instruction has committed.
- In IDLE: suppresses start.

rst mid-operation: immediately IDLE with all outputs at reset values.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 at T -> at T+2: write_en=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy low at T+3.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIVU a=100, b=7 -> write_en 33 edges after acceptance with lo=0x0000000E, hi=0x00000002; busy high for exactly 33 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> write_en at T+1 with lo=0xFFFFFFFF, hi=0x1234.
- DIV started at T, flush at T+10 -> no write_en or done ever, busy=0 at T+11. A start at T+11 (MTLO a=0xCAFE, hi_i=0x55) is accepted -> write at T+12 with hi=0x55, lo=0xCAFE.
- start pulsed while busy -> ignored. rst asserted mid-divide -> all outputs 0 next cycle, no write. flush and start in the same IDLE cycle -> not accepted.
